// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce/long-press FSM,
// registered level and strobes, and a count of completed short presses.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16000,
    parameter int unsigned LONG_PRESS_CYCLES = 8000000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       btn_usr,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned MAX_CNT = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                      DEBOUNCE_CYCLES - 1 : LONG_PRESS_CYCLES - 1;
    localparam int unsigned CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        PRESSED   = 3'd2,
        LONG_HELD = 3'd3,
        REL_DEB   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             from_long_q, from_long_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic [7:0]       count_q, count_d;
    logic             pressed;

    // Synchronizer idles at the unpressed raw level so reset never looks like a press.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            sync_q <= {2{BTN_ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], btn_usr};
        end
    end

    assign pressed = sync_q[1] ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            from_long_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            from_long_q <= from_long_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        from_long_d = from_long_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_DEB;
                    deb_d   = '0;
                end
            end
            PRESS_DEB: begin
                if (!pressed) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d     = REL_DEB;
                    deb_d       = '0;
                    from_long_d = 1'b0;
                end else if (hold_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!pressed) begin
                    state_d     = REL_DEB;
                    deb_d       = '0;
                    from_long_d = 1'b1;
                end
            end
            REL_DEB: begin
                if (pressed) begin
                    // Returning edge counts as a held cycle, so the long-press
                    // deadline slips by exactly the cycles the button read released.
                    if (from_long_q) begin
                        state_d = LONG_HELD;
                    end else if (hold_q == LONG_LAST) begin
                        state_d = LONG_HELD;
                        long_d  = 1'b1;
                    end else begin
                        state_d = PRESSED;
                        hold_d  = hold_q + CNT_ONE;
                    end
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                    if (!from_long_q) begin
                        count_d = count_q + 8'd1;
                    end
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign btn_level        = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = rel_q;
    assign long_press_pulse = long_q;
    assign press_count      = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, active-low button.
module tb_btn_debounce;

    logic       clk_16mhz = 1'b0;
    logic       rst;
    logic       btn_usr;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [7:0] press_count;

    int total = 0;
    int bad   = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .BTN_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk_16mhz       (clk_16mhz),
        .rst             (rst),
        .btn_usr         (btn_usr),
        .btn_level       (btn_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse),
        .press_count     (press_count)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    // Advance one rising edge, then settle on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk_16mhz);
        @(negedge clk_16mhz);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn_usr = 1'b1;
        repeat (3) tick();
        total++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", press_count);
        end
        rst = 1'b0;
        repeat (5) tick();
        total++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset got=%b exp=0000",
                     {btn_level, press_pulse, release_pulse, long_press_pulse});
        end
    endtask

    // Clean press held into a long press, then a clean release.
    task automatic test_long_press();
        logic [3:0] got, exp;
        btn_usr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i >= 6, i == 6, 1'b0, i == 26};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL long_press i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        btn_usr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i < 6, 1'b0, i == 6, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL long_release i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL long_count got=%0d exp=0", press_count);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] got;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 6; i++) begin
                btn_usr = (i >= 3);
                tick();
                got = {btn_level, press_pulse, release_pulse, long_press_pulse};
                total++;
                if (got !== 4'b0000) begin
                    bad++;
                    $display("FAIL bounce r=%0d i=%0d got=%b exp=0000", r, i, got);
                end
            end
        end
        repeat (6) tick();
        total++;
        if ({btn_level, press_count} !== 9'd0) begin
            bad++;
            $display("FAIL bounce_final level=%b count=%0d exp level=0 count=0",
                     btn_level, press_count);
        end
    endtask

    task automatic test_short_presses();
        int np = 0;
        int nr = 0;
        int nl = 0;
        for (int p = 1; p <= 257; p++) begin
            for (int i = 0; i < 20; i++) begin
                btn_usr = (i >= 10);
                tick();
                np += int'(press_pulse);
                nr += int'(release_pulse);
                nl += int'(long_press_pulse);
                total++;
                if ($countones({press_pulse, release_pulse, long_press_pulse}) > 1) begin
                    bad++;
                    $display("FAIL pulse_exclusive p=%0d i=%0d got=%b", p, i,
                             {press_pulse, release_pulse, long_press_pulse});
                end
            end
            if (p == 256) begin
                total++;
                if (np !== 256 || nr !== 256 || press_count !== 8'd0) begin
                    bad++;
                    $display("FAIL short_256 press=%0d release=%0d count=%0d exp 256 256 0",
                             np, nr, press_count);
                end
            end
        end
        total++;
        if (press_count !== 8'd1) begin
            bad++;
            $display("FAIL short_257 count got=%0d exp=1", press_count);
        end
        total++;
        if (nl !== 0) begin
            bad++;
            $display("FAIL short_no_long got=%0d exp=0", nl);
        end
    endtask

    // Two-cycle release glitch while held: no release, long press slips by two cycles.
    task automatic test_release_bounce();
        logic [3:0] got, exp;
        btn_usr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i >= 6, i == 6, 1'b0, i == 28};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rel_bounce i=%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 10) btn_usr = 1'b1;
            if (i == 12) btn_usr = 1'b0;
        end
        btn_usr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i < 6, 1'b0, i == 6, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rel_bounce_release i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        total++;
        if (press_count !== 8'd1) begin
            bad++;
            $display("FAIL rel_bounce_count got=%0d exp=1", press_count);
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] got, exp;
        btn_usr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i >= 6, i == 6, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL pre_reset_press i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({btn_level, press_pulse, release_pulse, long_press_pulse, press_count} !== 12'd0) begin
            bad++;
            $display("FAIL async_reset got=%b count=%0d exp all zero",
                     {btn_level, press_pulse, release_pulse, long_press_pulse}, press_count);
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = {btn_level, press_pulse, release_pulse, long_press_pulse};
            exp = {i >= 6, i == 6, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL post_reset_press i=%0d got=%b exp=%b", i, got, exp);
            end
        end
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL post_reset_count got=%0d exp=0", press_count);
        end
        btn_usr = 1'b1;
        repeat (10) tick();
        total++;
        if ({btn_level, press_count} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL post_reset_release level=%b count=%0d exp level=0 count=1",
                     btn_level, press_count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_usr = 1'b1;
        test_reset();
        test_long_press();
        test_bounce();
        test_short_presses();
        test_release_bounce();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 16000, stable cycles required to accept a press or release (1 ms at 16 MHz); legal range >= 1.
- LONG_PRESS_CYCLES, 8000000, held cycles after an accepted press before a long press fires (0.5 s); legal range >= 1.
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.

REQ-002 Ports (name, direction, width, meaning):
- clk_16mhz, in, 1, sole clock; one clock, all logic on its rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- btn_usr, in, 1, raw asynchronous button pin.
- btn_level, out, 1, debounced pressed level (1 = pressed).
- press_pulse, out, 1, one-cycle strobe on an accepted press.
- release_pulse, out, 1, one-cycle strobe on an accepted release.
- long_press_pulse, out, 1, one-cycle strobe when a press reaches the long-press threshold.
- press_count, out, 8, count of completed short presses.

Function
REQ-003 btn_usr SHALL pass through a two-flop synchronizer; pressed = sync output XOR BTN_ACTIVE_LOW.
REQ-004 The FSM SHALL have five states: IDLE, PRESS_DEB, PRESSED, LONG_HELD, REL_DEB.
- One debounce counter; one hold counter.
- Each counter is sized to hold the larger of DEBOUNCE_CYCLES-1 and LONG_PRESS_CYCLES-1.
REQ-005 IDLE: if pressed, go to PRESS_DEB and clear the debounce counter; otherwise stay.
REQ-006 PRESS_DEB: if not pressed, go to IDLE and clear the debounce counter.
- Else if debounce counter == DEBOUNCE_CYCLES-1: go to PRESSED, set btn_level=1, pulse press_pulse, clear the hold counter.
- Else increment the debounce counter.
REQ-007 Press latency: if edge k is the first edge that samples raw pressed and the input stays pressed, press_pulse SHALL be high for exactly the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-008 PRESSED: if not pressed, go to REL_DEB with the debounce counter cleared.
- Else if hold counter == LONG_PRESS_CYCLES-1: go to LONG_HELD and pulse long_press_pulse.
- Else increment the hold counter.
REQ-009 LONG_HELD: if not pressed, go to REL_DEB with the debounce counter cleared; no further long_press_pulse for this press.
REQ-010 REL_DEB: the block SHALL record which state it came from (PRESSED or LONG_HELD).
- If pressed: return to the recorded state; the hold counter is frozen during REL_DEB and resumes from its held value.
- Else if debounce counter == DEBOUNCE_CYCLES-1: go to IDLE, set btn_level=0, pulse release_pulse.
- Otherwise increment the debounce counter.
REQ-011 On release acceptance from PRESSED, press_count SHALL increment by 1, wrapping 255 -> 0. Release from LONG_HELD SHALL NOT change press_count.
REQ-012 At most one of press_pulse, release_pulse and long_press_pulse SHALL be high in any cycle. All outputs SHALL be registered.
REQ-013 btn_level SHALL remain 1 throughout PRESSED, LONG_HELD and REL_DEB.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no output change in either direction.

Reset
REQ-015 While rst=1, the block SHALL hold:
- FSM state = IDLE, both counters = 0, origin flag = PRESSED.
- Synchronizer flops = unpressed raw level (BTN_ACTIVE_LOW).
- btn_level=0, all pulses=0, press_count=0.
REQ-016 After reset deasserts with the button still held, the block SHALL treat it as a new press: full debounce, then press_pulse.
REQ-017 Reset asserted mid-operation SHALL immediately force the REQ-015 values with no pulse emitted.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, BTN_ACTIVE_LOW=1)
REQ-018 Clean press: btn_usr falls before edge k and stays low -> press_pulse high only after edge k+6, btn_level=1 from the same cycle; no long_press_pulse before edge k+26.
REQ-019 Long press: hold low -> long_press_pulse one cycle after edge k+26.
- Then release, stable -> release_pulse once, btn_level=0, press_count unchanged (0).
REQ-020 Bounce rejection: raw low for 3 synchronized cycles, then high, repeated 10 times -> no pulses, btn_level=0, press_count=0.
REQ-021 Short presses: 256 clean short press/release pairs -> 256 press_pulse and 256 release_pulse, press_count wraps to 0; after 257 pairs press_count=1.
REQ-022 Release bounce: while PRESSED, raw high for 2 cycles then low -> no release_pulse, btn_level stays 1; hold counter resumes and long_press_pulse timing is delayed by exactly the bounce duration.
REQ-023 Reset mid-press: assert rst in PRESSED -> all outputs 0 immediately.
- Deassert with the button held -> press_pulse 6 cycles after the first sampling edge, press_count=0.
